// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// default sizing constants and a constant-evaluable ceil(log2) helper.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_STOP
  } state_e;

  localparam int POS_W       = 10;
  localparam int SER_CLK_DIV = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_half_tick.sv
// Half-bit timebase: pulses tick on the last cycle of every CLK_DIV-cycle
// window while en is high; dropping en restarts the window.
module serial_half_tick
  import serial_pkg::*;
#(
  parameter int CLK_DIV = SER_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  // A one-cycle window still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (clog2(CLK_DIV) > 0) ? clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || tick) cnt_d = '0;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises one latched DATA_W-bit word per handshake as START, data bits,
// optional ACK slot and STOP on a registered SCL/SDA pair.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W    = POS_W,
  parameter int CLK_DIV   = SER_CLK_DIV,
  parameter int MSB_FIRST = 0,
  parameter int ACK_EN    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              scl,
  output logic              sda_out,
  output logic              sda_oe,
  input  logic              sda_in,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  localparam int BIT_W = clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [1:0]        half_q, half_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ack_err_q, ack_err_d;
  logic              done_q, done_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              tick_en, tick;

  assign tick_en = (state_q != ST_IDLE);

  serial_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tick_en),
    .tick    (tick)
  );

  assign tx_ready = (state_q == ST_IDLE);
  assign scl      = scl_q;
  assign sda_out  = sda_q;
  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          ack_err_d = 1'b0;
          state_d   = ST_START;
          half_d    = 2'd0;
          bit_d     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else begin
            state_d = ST_DATA;
            half_d  = 2'd0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else if (bit_q == LAST_BIT) begin
            state_d = (ACK_EN != 0) ? ST_ACK : ST_STOP;
            half_d  = 2'd0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            half_d  = 2'd0;
            shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else begin
            ack_err_d = sda_in;
            state_d   = ST_STOP;
            half_d    = 2'd0;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (half_q != 2'd2) begin
            half_d = half_q + 2'd1;
          end else begin
            state_d = ST_IDLE;
            half_d  = 2'd0;
            bit_d   = '0;
            shift_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so they change on the same
  // edge as the state register, keeping SCL/SDA glitch-free and aligned.
  always_comb begin
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    oe_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_IDLE: ;
      ST_START: begin
        scl_d = (half_d == 2'd0);
        sda_d = 1'b0;
      end
      ST_DATA: begin
        scl_d = (half_d == 2'd1);
        sda_d = (MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0];
      end
      ST_ACK: begin
        scl_d = (half_d == 2'd1);
        oe_d  = 1'b0;
      end
      ST_STOP: begin
        scl_d = (half_d != 2'd0);
        sda_d = (half_d == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      half_q    <= 2'd0;
      bit_q     <= '0;
      shift_q   <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      oe_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three configurations sharing one clock
// and reset, each frame compared cycle by cycle against a waveform model.
module tb_serial_frame_tx;

  logic clk;
  logic reset_n;

  logic [9:0]  tx_data_a;
  logic        tx_valid_a, tx_ready_a, scl_a, sda_a, oe_a, sda_in_a, busy_a, done_a, ack_err_a;
  logic [15:0] tx_data_b;
  logic        tx_valid_b, tx_ready_b, scl_b, sda_b, oe_b, sda_in_b, busy_b, done_b, ack_err_b;
  logic [0:0]  tx_data_c;
  logic        tx_valid_c, tx_ready_c, scl_c, sda_c, oe_c, sda_in_c, busy_c, done_c, ack_err_c;

  int n_tests = 0;
  int n_fail  = 0;

  serial_frame_tx u_dut_a (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .scl(scl_a), .sda_out(sda_a), .sda_oe(oe_a),
    .sda_in(sda_in_a), .busy(busy_a), .done(done_a), .ack_err(ack_err_a)
  );

  serial_frame_tx #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1), .ACK_EN(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .scl(scl_b), .sda_out(sda_b), .sda_oe(oe_b),
    .sda_in(sda_in_b), .busy(busy_b), .done(done_b), .ack_err(ack_err_b)
  );

  serial_frame_tx #(.DATA_W(1), .CLK_DIV(1), .MSB_FIRST(0), .ACK_EN(0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
    .tx_ready(tx_ready_c), .scl(scl_c), .sda_out(sda_c), .sda_oe(oe_c),
    .sda_in(sda_in_c), .busy(busy_c), .done(done_c), .ack_err(ack_err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pin waveform, one bit per cycle from the first START cycle.
  // m masks out SDA during the ACK slot, where the line is released.
  task automatic model_frame(input int div, input int w, input int ack, input int msb,
                             input logic [31:0] data,
                             output logic [255:0] s, output logic [255:0] d,
                             output logic [255:0] o, output logic [255:0] m,
                             output int len);
    int h, k;
    len = div * (2 + 2*w + 2*ack + 3);
    s = '0; d = '0; o = '0; m = '0;
    for (int i = 0; i < len; i++) begin
      h = i / div;
      m[i] = 1'b1;
      o[i] = 1'b1;
      if (h < 2) begin
        s[i] = (h == 0);
        d[i] = 1'b0;
      end else if (h < 2 + 2*w) begin
        k = h - 2;
        s[i] = (k % 2 == 1);
        d[i] = data[(msb != 0) ? (w - 1 - k/2) : (k/2)];
      end else if (ack != 0 && h < 4 + 2*w) begin
        s[i] = (h - 2 - 2*w == 1);
        o[i] = 1'b0;
        m[i] = 1'b0;
      end else begin
        k = h - (2 + 2*w + 2*ack);
        s[i] = (k != 0);
        d[i] = (k == 2);
      end
    end
  endtask

  task automatic send(input int id, input logic [31:0] data);
    case (id)
      0: begin tx_data_a = data[9:0];  tx_valid_a = 1'b1; end
      1: begin tx_data_b = data[15:0]; tx_valid_b = 1'b1; end
      default: begin tx_data_c = data[0:0]; tx_valid_c = 1'b1; end
    endcase
    step();
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    tx_valid_c = 1'b0;
  endtask

  task automatic status(input int id, output logic dn, output logic rdy,
                        output logic bsy, output logic ae);
    case (id)
      0: begin dn = done_a; rdy = tx_ready_a; bsy = busy_a; ae = ack_err_a; end
      1: begin dn = done_b; rdy = tx_ready_b; bsy = busy_b; ae = ack_err_b; end
      default: begin dn = done_c; rdy = tx_ready_c; bsy = busy_c; ae = ack_err_c; end
    endcase
  endtask

  task automatic capture(input int id, input int len,
                         output logic [255:0] s, output logic [255:0] d,
                         output logic [255:0] o, output logic [255:0] b,
                         output logic [255:0] dn);
    s = '0; d = '0; o = '0; b = '0; dn = '0;
    for (int i = 0; i < len; i++) begin
      case (id)
        0: begin s[i] = scl_a; d[i] = sda_a; o[i] = oe_a; b[i] = busy_a; dn[i] = done_a; end
        1: begin s[i] = scl_b; d[i] = sda_b; o[i] = oe_b; b[i] = busy_b; dn[i] = done_b; end
        default: begin s[i] = scl_c; d[i] = sda_c; o[i] = oe_c; b[i] = busy_c; dn[i] = done_c; end
      endcase
      step();
    end
  endtask

  // Called on the first START cycle; leaves the bench on the done cycle.
  task automatic verify(input string pfx, input int id, input int div, input int w,
                        input int ack, input int msb, input logic [31:0] data,
                        output logic [255:0] os, output logic [255:0] od);
    logic [255:0] es, ed, eo, em, eb, oo, ob, odn;
    logic dn, rdy, bsy, ae;
    int len;
    model_frame(div, w, ack, msb, data, es, ed, eo, em, len);
    eb = '0;
    for (int i = 0; i < len; i++) eb[i] = 1'b1;
    capture(id, len, os, od, oo, ob, odn);
    check({pfx, ":scl"}, os, es);
    check({pfx, ":sda"}, od & em, ed & em);
    check({pfx, ":sda_oe"}, oo, eo);
    check({pfx, ":busy"}, ob, eb);
    check({pfx, ":no_early_done"}, odn, '0);
    status(id, dn, rdy, bsy, ae);
    check({pfx, ":done_at_end"}, 256'(dn), 256'(1));
    check({pfx, ":ready_at_done"}, 256'(rdy), 256'(1));
    check({pfx, ":idle_busy"}, 256'(bsy), 256'(0));
  endtask

  initial begin
    logic [255:0] os, od;
    logic dn, rdy, bsy, ae;
    int viol;

    reset_n = 1'b0;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
    tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
    sda_in_a = 1'b0; sda_in_b = 1'b0; sda_in_c = 1'b0;
    step();
    step();
    check("reset:scl", 256'(scl_a), 256'(1));
    check("reset:sda", 256'(sda_a), 256'(1));
    check("reset:oe", 256'(oe_a), 256'(1));
    check("reset:busy_done_err", 256'({busy_a, done_a, ack_err_a}), 256'(0));
    reset_n = 1'b1;
    step();
    check("reset:ready", 256'(tx_ready_a), 256'(1));

    // 1: defaults, 10'h2A5 LSB first, ACK acknowledged
    send(0, 32'h2A5);
    verify("t1", 0, 4, 10, 1, 0, 32'h2A5, os, od);
    check("t1:start_window", 256'({os[7:0], od[7:0]}), 256'(16'h0F00));
    check("t1:bit0_1", 256'(od[15:8]), 256'(8'hFF));
    check("t1:bit1_0", 256'(od[23:16]), 256'(8'h00));
    status(0, dn, rdy, bsy, ae);
    check("t1:ack_ok", 256'(ae), 256'(0));
    step();

    // 2: NACK sets ack_err, next accept clears it
    sda_in_a = 1'b1;
    send(0, 32'h0F0);
    verify("t2a", 0, 4, 10, 1, 0, 32'h0F0, os, od);
    status(0, dn, rdy, bsy, ae);
    check("t2:nack_sticky", 256'(ae), 256'(1));
    step();
    step();
    status(0, dn, rdy, bsy, ae);
    check("t2:still_sticky_idle", 256'(ae), 256'(1));
    sda_in_a = 1'b0;
    send(0, 32'h133);
    status(0, dn, rdy, bsy, ae);
    check("t2:cleared_on_accept", 256'(ae), 256'(0));
    verify("t2b", 0, 4, 10, 1, 0, 32'h133, os, od);
    status(0, dn, rdy, bsy, ae);
    check("t2:ack_ok", 256'(ae), 256'(0));
    step();

    // 3: MSB first, 16 bits
    send(1, 32'h8001);
    verify("t3", 1, 4, 16, 1, 1, 32'h8001, os, od);
    check("t3:first_bit", 256'(od[15:8]), 256'(8'hFF));
    check("t3:last_bit", 256'(od[135:128]), 256'(8'hFF));
    check("t3:middle_zero", 256'(od[127:16]), 256'(0));
    step();

    // 4: back-to-back with tx_valid held; mid-frame data changes ignored
    tx_data_a = 10'h3FF;
    tx_valid_a = 1'b1;
    step();
    tx_data_a = 10'h000;
    verify("t4a", 0, 4, 10, 1, 0, 32'h3FF, os, od);
    step();
    check("t4:second_accept_busy", 256'(busy_a), 256'(1));
    check("t4:second_start", 256'({scl_a, sda_a}), 256'(2'b10));
    tx_data_a = 10'h3FF;
    tx_valid_a = 1'b0;
    verify("t4b", 0, 4, 10, 1, 0, 32'h000, os, od);
    step();

    // 5: reset mid-DATA (bit 5), then recover
    send(0, 32'h2A5);
    for (int i = 0; i < 50; i++) step();
    check("t5:in_bit5", 256'(busy_a), 256'(1));
    reset_n = 1'b0;
    #1;
    check("t5:async_lines", 256'({scl_a, sda_a, oe_a}), 256'(3'b111));
    check("t5:async_busy", 256'(busy_a), 256'(0));
    step();
    reset_n = 1'b1;
    step();
    check("t5:ready_after", 256'(tx_ready_a), 256'(1));
    send(0, 32'h155);
    verify("t5", 0, 4, 10, 1, 0, 32'h155, os, od);
    step();

    // 6: CLK_DIV=1, ACK off, single bit
    send(2, 32'h1);
    verify("t6", 2, 1, 1, 0, 0, 32'h1, os, od);
    viol = 0;
    for (int i = 1; i < 7; i++)
      if (os[i-1] && os[i] && (od[i-1] != od[i]) && i != 6) viol++;
    check("t6:sda_stable_scl_high", 256'(viol), 256'(0));
    status(2, dn, rdy, bsy, ae);
    check("t6:no_ack_err", 256'(ae), 256'(0));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parametrised serial frame transmitter that replaces the fixed 10-bit position serialiser. It accepts a DATA_W-bit word over a valid/ready handshake and latches it, so the word is held stable for the whole frame. It then emits one frame on a two-wire SCL/SDA link: START, data bits, optional ACK slot, STOP. SCL is a divided, registered clock rather than a gated system clock. The block sits between the position logic and the board pins; SDA is split into out/oe/in for the top-level tristate.

Parameters:
DATA_W, 10, payload bits per frame (1..32)
CLK_DIV, 4, clk cycles per SCL half-period (>=1)
MSB_FIRST, 0, 0 = bit 0 first, 1 = bit DATA_W-1 first
ACK_EN, 1, 1 = insert ACK slot after data, 0 = omit it

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
tx_data  in  DATA_W  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block idle and able to accept
scl  out  1  serial clock, registered
sda_out  out  1  SDA drive level, registered
sda_oe  out  1  1 = drive sda_out, 0 = release (ACK slot)
sda_in  in  1  SDA pin sampled value
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
ack_err  out  1  NACK seen in last frame (sticky until next accept)

Behaviour:
- Reset (reset_n low, takes effect immediately, including mid-frame):
  - state=IDLE, scl=1, sda_out=1, sda_oe=1.
  - busy=0, done=0, ack_err=0, shift register and counters cleared.
  - The line returns to idle-high with no STOP sequence.
- Timing base: a half-bit tick every CLK_DIV clk cycles. Each "half" below lasts exactly CLK_DIV cycles.
- tx_ready = (state==IDLE). A handshake occurs in a cycle where tx_valid && tx_ready.
  - On the handshake, tx_data is latched into the shift register and ack_err is cleared.
  - The START half-1 levels appear from the next cycle.
  - tx_data and tx_valid are ignored outside IDLE.
- States and output levels:
  - IDLE: scl=1, sda_out=1, sda_oe=1, busy=0.
  - START: half1 scl=1, sda=0; half2 scl=0, sda=0.
  - DATA: per bit, half1 scl=0, sda=bit; half2 scl=1, sda=bit. DATA_W bits in total, order set by MSB_FIRST. SDA changes only while SCL is low.
  - ACK (only if ACK_EN): sda_oe=0 for both halves; half1 scl=0, half2 scl=1. sda_in is sampled on the last clk of half2, and ack_err <= sda_in (1 = NACK).
  - STOP: half1 scl=0, sda=0; half2 scl=1, sda=0; half3 scl=1, sda=1.
  - Then IDLE. done=1 for exactly the first IDLE cycle, and tx_ready is 1 in that same cycle.
- busy = 1 from the cycle after the handshake through the last STOP cycle.
- Frame length: CLK_DIV*(2 + 2*DATA_W + 2*ACK_EN + 3) cycles. With defaults this is 4*27 = 108.
- Back-to-back: with tx_valid held high, the next handshake occurs on the done cycle. Minimum spacing between handshakes is frame length + 1.
- ACK_EN=0: sda_oe stays 1 for the whole frame and ack_err remains 0.
- Counters: half-tick counter is clog2(CLK_DIV) bits, wrapping at CLK_DIV-1. Bit counter is clog2(DATA_W+1) bits, compared only against DATA_W-1, so it never wraps within a frame.
- CLK_DIV=1: every half lasts exactly one cycle; the behaviour is otherwise identical.

Decomposition:
- Shared package serial_pkg:
  - state encoding (IDLE, START, DATA, ACK, STOP);
  - a clog2 function;
  - default constants POS_W=10 and SER_CLK_DIV=4.
- One sub-module, serial_half_tick (clk, reset_n, en, tick):
  - en=0 clears the count;
  - tick pulses every CLK_DIV cycles while en=1.
- The FSM, shift register and output registers stay in serial_frame_tx.

Test Plan:
1. Defaults, tx_data=10'h2A5, one handshake at cycle N:
   - scl/sda show START at N+1..N+8;
   - LSB-first data bits 1,0,1,0,0,1,0,1,0,1, each stable for 8 cycles;
   - sda_oe=0 during the ACK slot;
   - done at N+109.
2. ACK check, sda_in held 1 during ACK: ack_err=1 after frame. Next handshake clears it; a frame with sda_in=0 leaves it 0.
3. MSB_FIRST=1, DATA_W=16, tx_data=16'h8001:
   - first data bit 1, then 14 zeros, then 1;
   - frame is 4*(2+32+2+3)=156 cycles.
4. tx_valid held high, two words 10'h3FF then 10'h000:
   - second handshake occurs exactly on the first frame's done cycle;
   - tx_data changes mid-frame do not alter the bits sent.
5. reset_n pulsed low mid-DATA (bit 5): outputs go to scl=1, sda_out=1, sda_oe=1, busy=0 immediately; after release tx_ready=1 and a new frame transmits correctly.
6. CLK_DIV=1, ACK_EN=0, DATA_W=1, tx_data=1:
   - frame is 7 cycles;
   - sda_oe never 0;
   - SDA never changes while scl=1 except at the START fall and STOP rise.
